// File: rtl/uart_apb_sched_pkg.sv
// Shared types and constants for the two-requester APB scheduler in front of uart_top.
package uart_apb_sched_pkg;

    localparam int unsigned APB_AW          = 32;
    localparam int unsigned APB_DW          = 32;
    localparam int unsigned APB_SW          = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic [APB_AW-1:0] addr;
        logic [APB_DW-1:0] wdata;
        logic [APB_SW-1:0] strb;
    } apb_req_t;

    // Reads never drive byte strobes onto the bus.
    function automatic apb_req_t pack_req(
        input logic              write,
        input logic [APB_AW-1:0] addr,
        input logic [APB_DW-1:0] wdata,
        input logic [APB_SW-1:0] strb
    );
        apb_req_t r;
        r.write = write;
        r.addr  = addr;
        r.wdata = wdata;
        r.strb  = write ? strb : '0;
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer moves only on an update strobe.
module uart_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    input  logic       upd_i,
    output logic [1:0] grant_o,
    output logic       last_o
);

    logic last_q, last_d;

    always_comb begin
        grant_o = '0;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
                default: grant_o = '0;
            endcase
        end
        last_d = (upd_i && (grant_o != '0)) ? grant_o[1] : last_q;
    end

    // Pointer resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/uart_apb_sched.sv
// APB master serialising two requesters onto one uart_top slave, with wait-state timeout.
module uart_apb_sched
    import uart_apb_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_write,
    input  logic [APB_AW-1:0] r0_addr,
    input  logic [APB_DW-1:0] r0_wdata,
    input  logic [APB_SW-1:0] r0_strb,
    output logic              r0_done,
    output logic [APB_DW-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_write,
    input  logic [APB_AW-1:0] r1_addr,
    input  logic [APB_DW-1:0] r1_wdata,
    input  logic [APB_SW-1:0] r1_strb,
    output logic              r1_done,
    output logic [APB_DW-1:0] r1_rdata,
    output logic              r1_err,

    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_AW-1:0] paddr,
    output logic [APB_DW-1:0] pwdata,
    output logic [APB_SW-1:0] pstrb,
    input  logic [APB_DW-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    apb_req_t          req_q, req_d;
    logic [7:0]        wait_q, wait_d;
    logic [1:0]        done_q, done_d;
    logic [APB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        grant;
    logic              last_served;
    logic              arb_en;
    logic              accept;

    assign arb_en = (state_q == IDLE) && !preset;
    assign accept = |grant;

    uart_rr_arb2 u_arb (
        .clk_i   (pclk),
        .rst_i   (preset),
        .valid_i ({r1_valid, r0_valid}),
        .en_i    (arb_en),
        .upd_i   (accept),
        .grant_o (grant),
        .last_o  (last_served)
    );

    // The arbiter pointer doubles as the owner of the in-flight transfer.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wait_d  = wait_q;
        done_d  = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    req_d   = pack_req(r1_write, r1_addr, r1_wdata, r1_strb);
                    state_d = SETUP;
                end else if (grant[0]) begin
                    req_d   = pack_req(r0_write, r0_addr, r0_wdata, r0_strb);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                psel    = 1'b1;
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    state_d             = IDLE;
                    done_d[last_served] = 1'b1;
                    rdata_d             = req_q.write ? '0 : prdata;
                    err_d               = pslverr;
                end else if (wait_q == WAIT_LAST) begin
                    state_d             = IDLE;
                    done_d[last_served] = 1'b1;
                    err_d               = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            req_q   <= '0;
            wait_q  <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];

    assign r0_done  = done_q[0];
    assign r0_rdata = done_q[0] ? rdata_q : '0;
    assign r0_err   = done_q[0] & err_q;
    assign r1_done  = done_q[1];
    assign r1_rdata = done_q[1] ? rdata_q : '0;
    assign r1_err   = done_q[1] & err_q;

    assign pwrite = req_q.write;
    assign paddr  = req_q.addr;
    assign pwdata = req_q.wdata;
    assign pstrb  = req_q.strb;

endmodule

// File: tb/tb_uart_apb_sched.sv
// Scoreboard bench for uart_apb_sched driving a configurable wait-state APB slave model.
module tb_uart_apb_sched;

    logic        pclk = 1'b0;
    logic        preset;

    logic        r0_valid, r0_ready, r0_write, r0_done, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_strb;
    logic        r1_valid, r1_ready, r1_write, r1_done, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_strb;

    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;

    int          sl_wait = 0;
    logic        sl_never = 1'b0;
    logic [31:0] sl_rdata = 32'h0;
    logic        sl_err = 1'b0;
    logic        sl_err_wait = 1'b0;
    int          acc_cnt = 0;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 pclk = ~pclk;

    uart_apb_sched #(.TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_write(r0_write), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_strb(r0_strb), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_write(r1_write), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_strb(r1_strb), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .r1_err(r1_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Slave: pready after sl_wait unready ACCESS cycles; prdata/pslverr carry decoys otherwise.
    always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

    always_comb begin
        pready  = psel && penable && !sl_never && (acc_cnt >= sl_wait);
        prdata  = pready ? sl_rdata : 32'hDEAD_BEEF;
        pslverr = pready ? sl_err : sl_err_wait;
    end

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (r0_done || r1_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: r0_done=%b r1_done=%b expected no completion",
                         r0_done, r1_done);
            end else begin
                e = sb.pop_front();
                check("done_who", {r0_done, r1_done}, (e.req == 0) ? 2'b10 : 2'b01);
                check("done_rdata", (e.req == 0) ? r0_rdata : r1_rdata, e.rdata);
                check("done_err", (e.req == 0) ? r0_err : r1_err, e.err);
                check("other_side_zero", (e.req == 0) ? {r1_rdata, r1_err} : {r0_rdata, r0_err}, 0);
            end
        end else begin
            check("quiet_outputs", {r0_rdata, r0_err, r1_rdata, r1_err}, 0);
        end
    end

    task automatic drive(input int n, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (n == 0) begin
            r0_write = w; r0_addr = a; r0_wdata = d; r0_strb = s; r0_valid = 1'b1;
        end else begin
            r1_write = w; r1_addr = a; r1_wdata = d; r1_strb = s; r1_valid = 1'b1;
        end
    endtask

    // Returns #1 after the acceptance edge, i.e. in the SETUP cycle.
    task automatic issue(input int n, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        drive(n, w, a, d, s);
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if ((n == 0) ? r0_ready : r1_ready) begin
                @(posedge pclk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge pclk);
            end
        end
        if (n == 0) r0_valid = 1'b0;
        else        r1_valid = 1'b0;
        check("accept_in_time", ok, 1'b1);
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge pclk);
        #1;
    endtask

    initial begin
        int         grants[$];
        int         gcyc[$];
        int         n;
        logic [3:0] g;

        preset = 1'b1;
        r0_valid = 1'b1; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0; r0_strb = '0;
        r1_valid = 1'b1; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0; r1_strb = '0;
        repeat (3) @(negedge pclk);
        #1;
        check("reset_apb", {psel, penable, pwrite, paddr, pwdata, pstrb}, 0);
        check("reset_ready", {r0_ready, r1_ready}, 0);
        check("reset_done", {r0_done, r1_done}, 0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        preset   = 1'b0;

        // Zero-wait write from r0
        sl_wait = 0; sl_rdata = 32'h1234;
        sb.push_back('{0, 32'h0, 1'b0});
        issue(0, 1'b1, 32'h4, 32'h55, 4'hF);
        check("setup_apb", {psel, penable, pwrite, paddr, pwdata, pstrb},
              {1'b1, 1'b0, 1'b1, 32'h4, 32'h55, 4'hF});
        cyc(1);
        check("access_apb", {psel, penable, paddr}, {1'b1, 1'b1, 32'h4});
        cyc(1);
        check("wr_done_at_3", {r0_done, psel, penable}, 3'b100);

        // Round-robin from a fresh reset, both requesters always valid
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        drive(0, 1'b1, 32'h10, 32'hA0, 4'hF);
        drive(1, 1'b1, 32'h14, 32'hB0, 4'h3);
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            #1;
            if (r0_ready && r1_ready) begin
                check("ready_onehot", {r0_ready, r1_ready}, 2'b10);
            end else if (r0_ready || r1_ready) begin
                n = r1_ready ? 1 : 0;
                grants.push_back(n);
                gcyc.push_back(c);
                sb.push_back('{n, 32'h0, 1'b0});
            end
            @(negedge pclk);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        check("rr_count", grants.size(), 4);
        if (grants.size() == 4) begin
            g = {grants[0][0], grants[1][0], grants[2][0], grants[3][0]};
            check("rr_order", g, 4'b0101);
            for (int k = 0; k < 3; k++) check("rr_spacing", gcyc[k+1] - gcyc[k], 3);
        end
        repeat (4) @(negedge pclk);

        // Read with two wait states; pstrb forced low on reads
        sl_wait = 2; sl_rdata = 32'hA5;
        sb.push_back('{1, 32'hA5, 1'b0});
        issue(1, 1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF);
        check("rd_setup", {psel, penable, pwrite, paddr, pstrb},
              {1'b1, 1'b0, 1'b0, 32'h8, 4'h0});
        for (int k = 2; k <= 4; k++) begin
            cyc(1);
            check("rd_access_stable", {psel, penable, pwrite, paddr, pstrb},
                  {1'b1, 1'b1, 1'b0, 32'h8, 4'h0});
        end
        cyc(1);
        check("rd_done_at_5", {r1_done, psel}, 2'b10);

        // Slave error with pready, then pslverr asserted only while not ready
        @(negedge pclk);
        sl_wait = 0; sl_err = 1'b1; sl_rdata = 32'h77;
        sb.push_back('{0, 32'h77, 1'b1});
        issue(0, 1'b0, 32'hC, 32'h0, 4'hF);
        cyc(3);
        check("err_one_cycle", {r0_done, r0_err, r0_rdata}, 0);
        @(negedge pclk);
        sl_wait = 2; sl_err = 1'b0; sl_err_wait = 1'b1; sl_rdata = 32'h66;
        sb.push_back('{0, 32'h66, 1'b0});
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        cyc(5);
        sl_err_wait = 1'b0;

        // Timeout on a read: 16 ACCESS cycles, then abort with error and zero data
        @(negedge pclk);
        sl_never = 1'b1;
        sb.push_back('{1, 32'h0, 1'b1});
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        cyc(16);
        check("to_psel_held", {psel, penable}, 2'b11);
        cyc(1);
        check("to_psel_drop", {psel, penable, r1_done}, 3'b001);
        sl_never = 1'b0;

        // Reset during ACCESS aborts silently and restores r0 tie priority
        @(negedge pclk);
        sl_never = 1'b1;
        issue(1, 1'b1, 32'h30, 32'h99, 4'hF);
        cyc(1);
        check("pre_rst_access", {psel, penable}, 2'b11);
        @(negedge pclk);
        preset = 1'b1;
        drive(0, 1'b1, 32'h40, 32'h11, 4'hF);
        drive(1, 1'b1, 32'h44, 32'h22, 4'hF);
        @(posedge pclk);
        #1;
        check("rst_mid_apb", {psel, penable}, 2'b00);
        check("ready_in_reset", {r0_ready, r1_ready}, 2'b00);
        @(negedge pclk);
        preset = 1'b0;
        sl_never = 1'b0;
        sl_wait = 0;
        #1;
        check("tie_after_reset", {r0_ready, r1_ready}, 2'b10);
        sb.push_back('{0, 32'h0, 1'b0});
        @(posedge pclk);
        #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge pclk);
        check("scoreboard_drained", sb.size(), 0);
        repeat (5) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/uart_apb_sched.md
UART_APB_SCHED -- requirements
Module: uart_apb_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles waited for pready before abort (legal range 2..255).
REQ-002 The block SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port preset, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have, for each requester n in {0,1}, the following ports:
- rn_valid, input, 1: transfer request.
- rn_ready, output, 1: request accepted this cycle.
- rn_write, input, 1: 1 = write, 0 = read.
- rn_addr, input, 32: APB address.
- rn_wdata, input, 32: write data.
- rn_strb, input, 4: write byte strobes.
- rn_done, output, 1: one-cycle completion pulse.
- rn_rdata, output, 32: read data, valid with rn_done.
- rn_err, output, 1: slave error or timeout, valid with rn_done.
REQ-005 The block SHALL have the following APB master ports, which connect to one uart_top instance:
- psel, output, 1.
- penable, output, 1.
- pwrite, output, 1.
- paddr, output, 32.
- pwdata, output, 32.
- pstrb, output, 4.
- prdata, input, 32.
- pready, input, 1.
- pslverr, input, 1.

Function
REQ-006 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-007 IDLE SHALL go to SETUP on acceptance, SETUP SHALL go to ACCESS unconditionally, and ACCESS SHALL go to IDLE on pready=1 or on timeout.
REQ-008 rn_ready SHALL be combinational: state==IDLE, rn_valid=1, and requester n is selected by the arbiter; at most one rn_ready is high per cycle.
REQ-009 A transfer SHALL be accepted at the clock edge where rn_valid and rn_ready are both 1; write, addr, wdata and strb are captured at that edge.
REQ-010 Arbitration SHALL be round-robin:
- If only one valid is high, that requester wins.
- If both are high, the requester not served last wins.
- The last-served pointer updates on acceptance only.
REQ-011 In the SETUP cycle, psel=1 and penable=0, with paddr, pwdata, pwrite and pstrb driven from the captured values.
REQ-012 In ACCESS cycles, psel=1 and penable=1, and all address/data/control outputs SHALL be held stable.
REQ-013 On a read, the block SHALL force pstrb to 4'b0000.
REQ-014 In IDLE, psel and penable SHALL be 0; paddr, pwdata, pwrite and pstrb SHALL hold their last values.
REQ-015 When ACCESS completes with pready=1, the cycle after SHALL carry completion to the served requester:
- rn_done=1 for exactly one cycle.
- rn_rdata = sampled prdata on a read, or 0 on a write.
- rn_err = sampled pslverr.
REQ-016 With a zero-wait slave, latency from acceptance edge to the rn_done cycle SHALL be 3 cycles; each wait state adds 1.
REQ-017 A wait counter SHALL count ACCESS cycles with pready=0; after TIMEOUT consecutive such cycles, the block SHALL:
- Return to IDLE and drop psel/penable.
- Pulse rn_done with rn_err=1 and rn_rdata=0.
REQ-018 pready and pslverr SHALL be ignored outside ACCESS.
REQ-019 pslverr SHALL be sampled only with pready=1.
REQ-020 A new acceptance SHALL be possible in the same cycle that rn_done pulses, because the state is IDLE then; this gives back-to-back throughput of one transfer per 3 cycles.
REQ-021 rn_done/rn_rdata/rn_err of the non-served requester SHALL stay 0.
REQ-022 rn_rdata and rn_err SHALL return to 0 in the cycle after the done pulse.

Reset
REQ-023 preset=1 at a clock edge SHALL force the state to IDLE, clear the wait counter, and set the last-served pointer to 1, so r0 wins the first tie.
REQ-024 On reset, all APB outputs SHALL be 0: psel, penable, pwrite, paddr, pwdata, pstrb.
REQ-025 On reset, rn_done, rn_rdata and rn_err SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL deassert psel/penable in the next cycle and produce no rn_done for the aborted transfer.
REQ-027 rn_ready SHALL be 0 while preset=1.

Structure
REQ-028 Package uart_apb_sched_pkg SHALL hold:
- The state enum (IDLE/SETUP/ACCESS).
- APB_AW=32, APB_DW=32, APB_SW=4.
- TIMEOUT_DEFAULT=16.
REQ-029 Round-robin selection SHALL be one sub-module, uart_rr_arb2, with inputs valid[1:0], an enable and an update strobe, and outputs grant[1:0] and the last-served pointer.
REQ-030 The remaining logic (FSM, capture registers, timeout counter, completion registers) SHALL live in uart_apb_sched.

Verification
REQ-031 After reset, r0 writes addr 0x04, wdata 0x55, strb 0xF with a zero-wait slave -> SETUP at +1, ACCESS at +2, r0_done=1 with r0_err=0 at +3, and psel low at +3.
REQ-032 r0 and r1 both hold valid continuously for 4 transfers -> grants go r0, r1, r0, r1, with accepts spaced 3 cycles apart.
REQ-033 r1 reads addr 0x08 while the slave holds pready=0 for 2 cycles and then returns prdata=0xA5 -> r1_done at +5 with r1_rdata=0xA5, and paddr is stable throughout.
REQ-034 The slave returns pready=1 with pslverr=1 -> rn_err=1 for one cycle; pslverr=1 with pready=0 is ignored.
REQ-035 The slave never asserts pready with TIMEOUT=16 -> after 16 ACCESS cycles, psel drops and rn_done=1 with rn_err=1 and rn_rdata=0.
REQ-036 preset is pulsed during ACCESS -> psel=0 and penable=0 the next cycle, no rn_done, and the next tie grants r0.
